// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_pkg;
  localparam int UART_CPB_DEFAULT = 1085;
  localparam int UART_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an async level input; resets to 1 (idle line).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized line, mid-bit sampling FSM, one-cycle valid/frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CPB = UART_CPB_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_Rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic [3:0] o_bit_count
);
  localparam logic [10:0] HALF_M1 = 11'(CPB / 2 - 1);
  localparam logic [10:0] FULL_M1 = 11'(CPB - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_Rx),
    .o_sync  (rx_s)
  );

  rx_state_e                   state_q, state_d;
  logic [10:0]                 cnt_q, cnt_d;
  logic [2:0]                  idx_q, idx_d;
  logic [UART_DATA_BITS-1:0]   sh_q, sh_d;
  logic [7:0]                  data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          // A start bit that is high again at mid-bit was a glitch
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          // Returning to IDLE at mid-stop lets a back-to-back start bit be caught
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    o_bit_count = 4'd0;
    if (state_q == DATA)      o_bit_count = {1'b0, idx_q};
    else if (state_q == STOP) o_bit_count = 4'd8;
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frame-level timing model at CPB=16 plus a CPB=1085 reset-abort scenario.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int H    = CPB / 2;
  localparam int CPBL = 1085;
  localparam int HL   = CPBL / 2;

  logic       clk, rst, rx, rst_l, rx_l;
  logic [7:0] o_data, o_data_l;
  logic       o_valid, o_frame_err, o_busy;
  logic       o_valid_l, o_frame_err_l, o_busy_l;
  logic [3:0] o_bit_count, o_bit_count_l;

  uart_rx #(.CPB(CPB)) dut (
    .clk(clk), .rst(rst), .i_Rx(rx), .o_data(o_data), .o_valid(o_valid),
    .o_frame_err(o_frame_err), .o_busy(o_busy), .o_bit_count(o_bit_count)
  );

  uart_rx #(.CPB(CPBL)) dut_l (
    .clk(clk), .rst(rst_l), .i_Rx(rx_l), .o_data(o_data_l), .o_valid(o_valid_l),
    .o_frame_err(o_frame_err_l), .o_busy(o_busy_l), .o_bit_count(o_bit_count_l)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Expected event of one frame: pulse kind, byte, pulse cycle, first data-bit window start
  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         t;
    int         s;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         total = 0, bad = 0;
  logic [7:0] model_data = 8'h00;
  int         nvalid = 0, nferr = 0;
  int         last_valid_cyc = 0, prev_valid_cyc = 0;
  int         t0_last = 0;
  bit         saw_busy = 0;
  int         nvalid_l = 0, last_valid_l = 0;
  logic [7:0] last_data_l = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d (cyc %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // Compare process for the CPB=16 instance
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_data = 8'h00;
    end else begin
      ev_t e;
      int  d;
      chk("pulse_exclusive", {31'd0, o_valid & o_frame_err}, 32'd0);
      while (evq.size() > 0 && cyc > evq[0].t + 2) begin
        total++; bad++;
        $display("FAIL missed_pulse: got none want pulse at cyc %0d (now %0d)", evq[0].t, cyc);
        void'(evq.pop_front());
      end
      if (o_valid || o_frame_err) begin
        if (evq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b want none (cyc %0d)",
                   o_valid, o_frame_err, cyc);
        end else begin
          e = evq.pop_front();
          chk("pulse_kind_ferr", {31'd0, o_frame_err}, {31'd0, e.ferr});
          chk_rng("pulse_time", cyc, e.t - 2, e.t + 2);
          if (!e.ferr) model_data = e.data;
        end
        if (o_valid) begin
          nvalid++;
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
        if (o_frame_err) nferr++;
      end
      chk("o_data", {24'd0, o_data}, {24'd0, model_data});
      if (evq.size() > 0) begin
        d = cyc - evq[0].s;
        if (d >= 0 && d < 9 * CPB && d % CPB == H) begin
          chk("bit_count", {28'd0, o_bit_count}, d / CPB);
          chk("busy_in_frame", {31'd0, o_busy}, 32'd1);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_busy) saw_busy = 1;
  end

  // Monitor for the CPB=1085 instance
  initial forever begin
    @(negedge clk);
    if (rst_l) begin
      total++;
      if (o_valid_l || o_frame_err_l || o_busy_l || o_data_l != 8'h00) begin
        bad++;
        $display("FAIL long_in_reset: got v=%0b fe=%0b busy=%0b data=%0h want all 0",
                 o_valid_l, o_frame_err_l, o_busy_l, o_data_l);
      end
    end else if (o_valid_l) begin
      nvalid_l++;
      last_valid_l = cyc;
      last_data_l  = o_data_l;
      total++;
      if (o_data_l == 8'hC3) begin
        bad++;
        $display("FAIL aborted_byte: got %0h want anything but c3", o_data_l);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit ok, input int xlow);
    ev_t e;
    t0_last = cyc + 1;
    e.ferr = !ok;
    e.data = b;
    e.s    = t0_last + 2 + H;
    e.t    = e.s + 9 * CPB;
    evq.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    if (!ok) begin
      repeat (xlow) @(negedge clk);
      chk("busy_wait_high", {31'd0, o_busy}, 32'd1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_after_high", {31'd0, o_busy}, 32'd0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (evq.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, evq.size() > 0}, 32'd0);
  endtask

  task automatic send_long(input logic [7:0] b);
    rx_l = 1'b0;
    repeat (CPBL) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_l = b[k];
      repeat (CPBL) @(negedge clk);
    end
    rx_l = 1'b1;
    repeat (CPBL) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int         nf, nb, t0l;
    rst = 1'b1; rst_l = 1'b1; rx = 1'b1; rx_l = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data",  {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("rst_bitcnt", {28'd0, o_bit_count}, 32'd0);
    rst = 1'b0; rst_l = 1'b0;

    // 1: idle line
    repeat (1000) @(negedge clk);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_pulses", nvalid + nferr, 0);

    // 2: single frame
    send(8'hA5, 1'b1, 0);
    wait_drain();
    chk_rng("a5_latency", last_valid_cyc - t0_last, 152, 156);
    chk("a5_data", {24'd0, o_data}, 32'h0000_00A5);
    chk("a5_no_ferr", nferr, 0);
    repeat (20) @(negedge clk);

    // 3: back-to-back
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    wait_drain();
    chk_rng("b2b_spacing", last_valid_cyc - prev_valid_cyc, 158, 162);
    chk("b2b_data", {24'd0, o_data}, 32'h0000_00FF);
    repeat (20) @(negedge clk);

    // 4: false start then a good frame
    saw_busy = 0;
    nb = nvalid;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_saw_busy", {31'd0, saw_busy}, 32'd1);
    chk("glitch_idle", {31'd0, o_busy}, 32'd0);
    chk("glitch_no_valid", nvalid, nb);
    send(8'h3C, 1'b1, 0);
    wait_drain();
    chk("3c_data", {24'd0, o_data}, 32'h0000_003C);
    repeat (20) @(negedge clk);

    // 5: framing error with break, then recovery
    nf = nferr;
    send(8'h55, 1'b0, 100);
    wait_drain();
    chk("ferr_count", nferr, nf + 1);
    chk("ferr_data_held", {24'd0, o_data}, 32'h0000_003C);
    send(8'h12, 1'b1, 0);
    wait_drain();
    chk("12_data", {24'd0, o_data}, 32'h0000_0012);

    // Random frames, gaps, stop-bit faults
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      send(b, $urandom_range(0, 3) != 0, $urandom_range(0, 40));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_drain();
    repeat (20) @(negedge clk);

    // 6: reset abort mid-frame at full baud divisor
    b = 8'hC3;
    rx_l = 1'b0;
    repeat (CPBL) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx_l = b[k];
      repeat (CPBL) @(negedge clk);
    end
    rx_l = b[4];
    repeat (HL) @(negedge clk);
    rst_l = 1'b1;
    #1;
    chk("abort_busy", {31'd0, o_busy_l}, 32'd0);
    chk("abort_bitcnt", {28'd0, o_bit_count_l}, 32'd0);
    repeat (20) @(negedge clk);
    rst_l = 1'b0;
    repeat (CPBL - HL - 20) @(negedge clk);
    for (int k = 5; k < 8; k++) begin
      rx_l = b[k];
      repeat (CPBL) @(negedge clk);
    end
    rx_l = 1'b1;
    repeat (13 * CPBL) @(negedge clk);
    nb  = nvalid_l;
    t0l = cyc + 1;
    send_long(8'h81);
    repeat (20) @(negedge clk);
    chk("long_valid_count", nvalid_l, nb + 1);
    chk("long_data", {24'd0, last_data_l}, 32'h0000_0081);
    chk_rng("long_latency", last_valid_l - t0l, 2 + HL + 9 * CPBL - 2, 2 + HL + 9 * CPBL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Basic UART receiver (8 data bits, no parity, 1 stop bit, LSB first, 115200 baud at 125 MHz). It is the receive-side companion to the team's UART transmitter. It deserializes the asynchronous `i_Rx` line into bytes and presents each byte with a single-cycle valid pulse. It sits between the board's serial RX pin and downstream logic, such as a BRAM writer.

## Interface
- `CPB`, default 1085: clocks per bit (125 MHz / 115200). Legal range 4..2047.
- `clk` in 1: 125 MHz system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_Rx` in 1: serial receive line, asynchronous to `clk`, idle high.
- `o_data` out 8: last correctly framed byte; holds its value until the next good byte.
- `o_valid` out 1: one-cycle high pulse; `o_data` is new this cycle.
- `o_frame_err` out 1: one-cycle high pulse; stop bit sampled low, byte discarded.
- `o_busy` out 1: high in any state except IDLE.
- `o_bit_count` out 4: debug; index of the data bit being received (0..7), 8 during STOP, 0 otherwise.

## Operation
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_busy`=0, `o_bit_count`=0.
  - Synchronizer flops are 1 (line idle). State is IDLE and the counter is 0.
- Input path:
  - `i_Rx` passes through a 2-flop synchronizer. Output is `rx_s`.
  - All decisions use `rx_s` only.
- Counter: 11-bit `cpb_cnt`. It resets to 0 on every state change and on every bit sample.
- State IDLE:
  - If `rx_s`==0, go to START with `cpb_cnt`=0.
  - Otherwise stay in IDLE.
- State START:
  - When `cpb_cnt`==CPB/2-1 (integer division), check `rx_s`.
  - If `rx_s`==0, go to DATA with bit index 0.
  - If `rx_s`==1 (glitch / false start), go back to IDLE. No output pulse.
- State DATA:
  - When `cpb_cnt`==CPB-1, shift `rx_s` into bit[index], LSB first.
  - After bit 7 is sampled, go to STOP.
- State STOP, when `cpb_cnt`==CPB-1:
  - If `rx_s`==1: `o_data` is loaded with the shift register, `o_valid` pulses, go to IDLE.
  - If `rx_s`==0: `o_frame_err` pulses, `o_data` is unchanged, go to WAIT_HIGH.
- State WAIT_HIGH (break / line stuck low):
  - Stay while `rx_s`==0.
  - Go to IDLE on the first `rx_s`==1. No new frame may start until then.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- `o_valid` and `o_frame_err` are never high in the same cycle. Each pulse is exactly one cycle.
- No flow control and no overrun detection. A consumer must take `o_data` before the next `o_valid`, i.e. within about 10·CPB cycles.

## Timing
- Let T0 be the first rising edge at which the first synchronizer flop captures a low level.
- IDLE→START occurs at edge T0+2.
- The start-bit check is at T0+2+CPB/2. Data bit k is sampled at T0+2+CPB/2+(k+1)·CPB. The stop bit is sampled at T0+2+CPB/2+9·CPB.
- `o_valid` (or `o_frame_err`) is high in the cycle following the stop-sample edge. Bench tolerance is ±2 cycles.
- Asserting `rst` mid-frame:
  - Outputs go to reset values immediately.
  - The partial byte is lost and no pulse is produced.
  - After release, a frame already in progress may cause a framing error or garbage; this is acceptable.
- Minimum gap between accepted frames: 9.5·CPB cycles of frame after the previous stop sample (no dead time).

## Structure
- Shared package `uart_pkg`:
  - Constants: `UART_CPB_DEFAULT`=1085, `UART_DATA_BITS`=8.
  - Receiver state encoding: IDLE, START, DATA, STOP, WAIT_HIGH.
- One sub-module: `uart_rx_sync`. It is a 2-flop synchronizer with async set-to-1 on `rst`, and is reusable for other async inputs.
- Everything else lives in a single FSM + counter + shift-register block.

## Test plan
Use CPB=16 for speed, except scenario 6.
1. Reset, line idle → all outputs 0, `o_busy`=0, no pulses for 1000 cycles.
2. Send 0xA5, 8N1 → exactly one `o_valid` pulse about 154 cycles after the start edge; `o_data`=0xA5; `o_frame_err` never high.
3. Send 0x00 then 0xFF back-to-back with no idle gap → two `o_valid` pulses 160 cycles apart, with data 0x00 then 0xFF.
4. Glitch low for 3 cycles on an idle line → `o_busy` high briefly, then IDLE; no `o_valid`, no `o_frame_err`. Then send 0x3C → received correctly.
5. Send 0x55 with the stop bit driven low and the line held low for 100 more cycles → one `o_frame_err`; `o_data` keeps its prior value; `o_busy` stays high until the line returns high. Then send 0x12 → `o_valid` with data 0x12.
6. CPB=1085: assert `rst` mid-frame at bit 4 of 0xC3, release, then send 0x81 → no pulse for the aborted frame; 0x81 is received correctly.
